// File: rtl/mmio_lsu_pkg.sv
// Shared constants, encodings and helpers for the MMIO load/store unit.
package mmio_lsu_pkg;

  localparam logic [11:0] ADDR_SW       = 12'h900;
  localparam logic [11:0] ADDR_LCD      = 12'h8A0;
  localparam logic [11:0] ADDR_LEDG     = 12'h890;
  localparam logic [11:0] ADDR_LEDR     = 12'h880;
  localparam logic [11:0] ADDR_HEX_BASE = 12'h800;

  localparam logic [2:0] LD_WORD = 3'b111;
  localparam logic [2:0] LD_HALF = 3'b011;
  localparam logic [2:0] LD_BYTE = 3'b001;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_READ = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_DMEM,
    SEL_SW,
    SEL_LCD,
    SEL_LEDG,
    SEL_LEDR,
    SEL_HEX
  } sel_e;

  // Align a read word to the addressed lane and apply size/sign handling.
  function automatic logic [31:0] lsu_extract(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [3:0]  op);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    if (!op[0]) return 32'h0;
    if (op[2]) return sh;
    if (op[1]) return op[3] ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
    return op[3] ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
  endfunction

endpackage

// File: rtl/mmio_lsu_dmem.sv
// Data memory: WORDS x 32 synchronous-read RAM with per-byte write enables.
module mmio_lsu_dmem #(
  parameter int WORDS = 512,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mmio_lsu.sv
// MMIO load/store unit: DMEM plus LCD/LED/HEX registers and a synchronised switch input.
// Optional build macro LSU_MISALIGN_CHK_EN: flag misaligned half/word accesses instead of truncating.
//
// state   | meaning
// IDLE    | ready for a request
// READ    | DMEM synchronous read in flight
// RESP    | response held until rsp_ready_i
module mmio_lsu
  import mmio_lsu_pkg::*;
#(
  parameter int DMEM_WORDS = 512,
  parameter int N_HEX      = 8,
  parameter int SW_SYNC    = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [31:0]        addr_i,
  input  logic               st_en_i,
  input  logic [3:0]         ld_op_i,
  input  logic [31:0]        st_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [31:0]        ld_data_o,
  output logic               err_o,
  input  logic [31:0]        io_sw_i,
  output logic [31:0]        io_lcd_o,
  output logic [31:0]        io_ledg_o,
  output logic [31:0]        io_ledr_o,
  output logic [N_HEX*32-1:0] io_hex_o
);

  localparam int AW = $clog2(DMEM_WORDS);

  state_t      state_q;
  logic        ready_en_q;
  logic        accept;
  logic [11:0] a_raw;
  logic [11:0] a_eff;
  logic        is_word;
  logic        is_half;
  logic        misalign;
  sel_e        sel;
  logic [2:0]  hex_idx;
  logic        unused_addr;

  logic [31:0] lcd_q;
  logic [31:0] ledg_q;
  logic [31:0] ledr_q;
  logic [31:0] hex_q [N_HEX];
  logic [31:0] sw_ff [SW_SYNC];
  logic [31:0] sw_sync;
  logic [31:0] periph_rd;

  logic [1:0]    off_q;
  logic [3:0]    op_q;
  logic [31:0]   ld_data_q;
  logic [3:0]    lane_mask;
  logic [3:0]    dm_be;
  logic [3:0]    dm_we;
  logic [31:0]   dm_wdata;
  logic [31:0]   dm_rdata;
  logic [AW-1:0] dm_addr;

  assign a_raw       = addr_i[11:0];
  assign unused_addr = ^addr_i[31:12];
  assign is_word     = (ld_op_i[2:0] == LD_WORD);
  assign is_half     = (ld_op_i[2:0] == LD_HALF);
  assign req_ready_o = (state_q == ST_IDLE) && ready_en_q;
  assign accept      = req_valid_i && req_ready_o;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign ld_data_o   = ld_data_q;

  always_comb begin
    a_eff    = a_raw;
    misalign = 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
    misalign = (is_word && (a_raw[1:0] != 2'b00)) || (is_half && a_raw[0]);
`else
    if (is_word)      a_eff[1:0] = 2'b00;
    else if (is_half) a_eff[0]   = 1'b0;
`endif
  end

  always_comb begin
    sel     = SEL_NONE;
    hex_idx = a_eff[6:4];
    if (a_eff == ADDR_SW)                         sel = SEL_SW;
    else if (a_eff == ADDR_LCD)                   sel = SEL_LCD;
    else if (a_eff == ADDR_LEDG)                  sel = SEL_LEDG;
    else if (a_eff == ADDR_LEDR)                  sel = SEL_LEDR;
    else if (!a_eff[11])                          sel = SEL_DMEM;
    else if ((a_eff[11:7] == ADDR_HEX_BASE[11:7]) && (a_eff[3:0] == 4'h0) &&
             (int'(a_eff[6:4]) < N_HEX))          sel = SEL_HEX;
  end

  // A word op encodes 3'b111, so it is widened to a full four-lane mask before shifting.
  assign lane_mask = is_word ? 4'b1111 : {1'b0, ld_op_i[2:0]};
  assign dm_be     = lane_mask << a_eff[1:0];
  assign dm_addr   = a_eff[AW+1:2];
  assign dm_we     = (accept && st_en_i && (sel == SEL_DMEM) && !misalign) ? dm_be : 4'b0000;

  always_comb begin
    dm_wdata = st_data_i;
    if (is_half)                          dm_wdata = {2{st_data_i[15:0]}};
    else if (ld_op_i[2:0] == LD_BYTE)     dm_wdata = {4{st_data_i[7:0]}};
  end

  mmio_lsu_dmem #(
    .WORDS (DMEM_WORDS)
  ) u_dmem (
    .clk_i (clk_i),
    .addr  (dm_addr),
    .we    (dm_we),
    .wdata (dm_wdata),
    .rdata (dm_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < SW_SYNC; k++) sw_ff[k] <= 32'h0;
    end else begin
      sw_ff[0] <= io_sw_i;
      for (int k = 1; k < SW_SYNC; k++) sw_ff[k] <= sw_ff[k-1];
    end
  end
  assign sw_sync = sw_ff[SW_SYNC-1];

  always_comb begin
    periph_rd = 32'h0;
    case (sel)
      SEL_SW:   periph_rd = sw_sync;
      SEL_LCD:  periph_rd = lcd_q;
      SEL_LEDG: periph_rd = ledg_q;
      SEL_LEDR: periph_rd = ledr_q;
      SEL_HEX: begin
        for (int k = 0; k < N_HEX; k++) begin
          if (hex_idx == k[2:0]) periph_rd = hex_q[k];
        end
      end
      default:  periph_rd = 32'h0;
    endcase
  end

  // Peripheral stores are always full-width, whatever the access size.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lcd_q  <= 32'h0;
      ledg_q <= 32'h0;
      ledr_q <= 32'h0;
      for (int k = 0; k < N_HEX; k++) hex_q[k] <= 32'h0;
    end else if (accept && st_en_i && !misalign) begin
      if (sel == SEL_LCD)  lcd_q  <= st_data_i;
      if (sel == SEL_LEDG) ledg_q <= st_data_i;
      if (sel == SEL_LEDR) ledr_q <= st_data_i;
      for (int k = 0; k < N_HEX; k++) begin
        if ((sel == SEL_HEX) && (hex_idx == k[2:0])) hex_q[k] <= st_data_i;
      end
    end
  end

  assign io_lcd_o  = lcd_q;
  assign io_ledg_o = ledg_q;
  assign io_ledr_o = ledr_q;

  for (genvar g = 0; g < N_HEX; g++) begin : g_hex
    assign io_hex_o[32*g +: 32] = hex_q[g];
  end

`ifdef LSU_MISALIGN_CHK_EN
  logic err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                          err_q <= 1'b0;
    else if (state_q == ST_IDLE && accept) err_q <= misalign;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      ready_en_q <= 1'b0;
      ld_data_q  <= 32'h0;
      off_q      <= 2'b00;
      op_q       <= 4'h0;
    end else begin
      ready_en_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            off_q <= a_eff[1:0];
            op_q  <= ld_op_i;
            if (st_en_i || misalign) begin
              ld_data_q <= 32'h0;
              state_q   <= ST_RESP;
            end else if (sel == SEL_DMEM) begin
              state_q <= ST_READ;
            end else begin
              ld_data_q <= periph_rd;
              state_q   <= ST_RESP;
            end
          end
        end
        ST_READ: begin
          ld_data_q <= lsu_extract(dm_rdata, off_q, op_q);
          state_q   <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_lsu.sv
// Directed vector bench for mmio_lsu, plus hand sequences for backpressure, sync, misalignment and reset.
module tb_mmio_lsu;

  localparam int N_HEX   = 8;
  localparam int SW_SYNC = 2;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               req_valid_i;
  logic               req_ready_o;
  logic [31:0]        addr_i;
  logic               st_en_i;
  logic [3:0]         ld_op_i;
  logic [31:0]        st_data_i;
  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic [31:0]        ld_data_o;
  logic               err_o;
  logic [31:0]        io_sw_i;
  logic [31:0]        io_lcd_o;
  logic [31:0]        io_ledg_o;
  logic [31:0]        io_ledr_o;
  logic [N_HEX*32-1:0] io_hex_o;

  mmio_lsu #(
    .DMEM_WORDS (512),
    .N_HEX      (N_HEX),
    .SW_SYNC    (SW_SYNC)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .addr_i      (addr_i),
    .st_en_i     (st_en_i),
    .ld_op_i     (ld_op_i),
    .st_data_i   (st_data_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .ld_data_o   (ld_data_o),
    .err_o       (err_o),
    .io_sw_i     (io_sw_i),
    .io_lcd_o    (io_lcd_o),
    .io_ledg_o   (io_ledg_o),
    .io_ledr_o   (io_ledr_o),
    .io_hex_o    (io_hex_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          st;
    logic [31:0] addr;
    logic [3:0]  op;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
    string       name;
  } vec_t;

  vec_t vecs [$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Issues one request; lat counts clock edges from the accepting edge until rsp_valid_o.
  task automatic do_req(input bit st, input logic [31:0] addr, input logic [3:0] op,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    int guard;
    guard = 0;
    while (!req_ready_o && guard < 20) begin
      @(posedge clk_i); #1;
      guard++;
    end
    st_en_i     = st;
    addr_i      = addr;
    ld_op_i     = op;
    st_data_i   = wd;
    req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    lat = 1;
    while (!rsp_valid_o && lat < 20) begin
      @(posedge clk_i); #1;
      lat++;
    end
    rd = ld_data_o;
    er = err_o;
    if (rsp_ready_i) begin
      @(posedge clk_i); #1;
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  bit          saw_rsp;

  initial begin
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    addr_i      = 32'h0;
    st_en_i     = 1'b0;
    ld_op_i     = 4'h0;
    st_data_i   = 32'h0;
    rsp_ready_i = 1'b1;
    io_sw_i     = 32'h0;

    vecs.push_back('{1'b1, 32'h004, 4'b0111, 32'hDEADBEEF, 32'h00000000, 1, "sw_004"});
    vecs.push_back('{1'b0, 32'h004, 4'b0111, 32'h0,        32'hDEADBEEF, 2, "lw_004"});
    vecs.push_back('{1'b1, 32'h007, 4'b0001, 32'h00000080, 32'h00000000, 1, "sb_007"});
    vecs.push_back('{1'b0, 32'h007, 4'b1001, 32'h0,        32'hFFFFFF80, 2, "lb_007"});
    vecs.push_back('{1'b0, 32'h007, 4'b0001, 32'h0,        32'h00000080, 2, "lbu_007"});
    vecs.push_back('{1'b0, 32'h004, 4'b0111, 32'h0,        32'h80ADBEEF, 2, "lw_004b"});
    vecs.push_back('{1'b0, 32'h006, 4'b1011, 32'h0,        32'hFFFF80AD, 2, "lh_006"});
    vecs.push_back('{1'b0, 32'h004, 4'b0011, 32'h0,        32'h0000BEEF, 2, "lhu_004"});
    vecs.push_back('{1'b0, 32'h004, 4'b1001, 32'h0,        32'hFFFFFFEF, 2, "lb_004"});
    vecs.push_back('{1'b0, 32'h004, 4'b0000, 32'h0,        32'h00000000, 2, "lop0_004"});
    vecs.push_back('{1'b1, 32'h008, 4'b0111, 32'h00000000, 32'h00000000, 1, "sw_008"});
    vecs.push_back('{1'b1, 32'h00A, 4'b0011, 32'hFFFF1234, 32'h00000000, 1, "sh_00A"});
    vecs.push_back('{1'b1, 32'h009, 4'b0001, 32'h000000AB, 32'h00000000, 1, "sb_009"});
    vecs.push_back('{1'b0, 32'h008, 4'b0111, 32'h0,        32'h1234AB00, 2, "lw_008"});
    vecs.push_back('{1'b1, 32'hFFFF07FC, 4'b0111, 32'hCAFEF00D, 32'h0,   1, "sw_7FC"});
    vecs.push_back('{1'b0, 32'h7FC, 4'b0111, 32'h0,        32'hCAFEF00D, 2, "lw_7FC"});
    vecs.push_back('{1'b1, 32'h830, 4'b0111, 32'h12345678, 32'h00000000, 1, "sw_hex3"});
    vecs.push_back('{1'b0, 32'h830, 4'b0111, 32'h0,        32'h12345678, 1, "lw_hex3"});
    vecs.push_back('{1'b0, 32'h830, 4'b1001, 32'h0,        32'h12345678, 1, "lb_hex3"});
    vecs.push_back('{1'b1, 32'h8A0, 4'b0011, 32'h0000ABCD, 32'h00000000, 1, "sh_lcd"});
    vecs.push_back('{1'b1, 32'h880, 4'b0111, 32'h00000055, 32'h00000000, 1, "sw_ledr"});
    vecs.push_back('{1'b1, 32'h890, 4'b0001, 32'h00C0FFEE, 32'h00000000, 1, "sb_ledg"});
    vecs.push_back('{1'b0, 32'h890, 4'b0111, 32'h0,        32'h00C0FFEE, 1, "lw_ledg"});
    vecs.push_back('{1'b0, 32'h8F0, 4'b0111, 32'h0,        32'h00000000, 1, "lw_unmap"});
    vecs.push_back('{1'b1, 32'h8F0, 4'b0111, 32'h77777777, 32'h00000000, 1, "sw_unmap"});
    vecs.push_back('{1'b1, 32'h900, 4'b0111, 32'h00000001, 32'h00000000, 1, "sw_sw"});
    vecs.push_back('{1'b0, 32'h900, 4'b0111, 32'h0,        32'h00000000, 1, "lw_sw0"});

    repeat (2) @(posedge clk_i);
    #1;
    check("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
    check("rst_ld_data", ld_data_o, 32'h0);
    check("rst_err", {31'b0, err_o}, 32'h0);
    check("rst_leds", io_lcd_o | io_ledg_o | io_ledr_o, 32'h0);
    check("rst_hex", {31'b0, io_hex_o == '0}, 32'h1);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check("rel_req_ready", {31'b0, req_ready_o}, 32'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i].st, vecs[i].addr, vecs[i].op, vecs[i].wdata, rd, er, lat);
      check({vecs[i].name, "_data"}, rd, vecs[i].exp_data);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      check({vecs[i].name, "_err"}, {31'b0, er}, 32'h0);
    end

    check("hex3_out", io_hex_o[127:96], 32'h12345678);
    check("hex_other", io_hex_o[95:0] == 96'h0 ? 32'h1 : 32'h0, 32'h1);
    check("lcd_out", io_lcd_o, 32'h0000ABCD);
    check("ledr_out", io_ledr_o, 32'h00000055);
    check("ledg_out", io_ledg_o, 32'h00C0FFEE);

    // HEX store visible right after the accepting edge
    st_en_i = 1'b1; addr_i = 32'h810; ld_op_i = 4'b0111; st_data_i = 32'h0BADF00D;
    req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    check("hex1_next", io_hex_o[63:32], 32'h0BADF00D);
    @(posedge clk_i); #1;

    // switch synchroniser: an immediate load still sees the old value
    io_sw_i = 32'h000000A5;
    do_req(1'b0, 32'h900, 4'b0111, 32'h0, rd, er, lat);
    check("sw_early", rd, 32'h0);
    do_req(1'b0, 32'h900, 4'b0111, 32'h0, rd, er, lat);
    check("sw_synced", rd, 32'h000000A5);
    check("sw_lat", 32'(lat), 32'd1);

    // backpressure
    rsp_ready_i = 1'b0;
    do_req(1'b0, 32'h004, 4'b0111, 32'h0, rd, er, lat);
    check("bp_lat", 32'(lat), 32'd2);
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", {31'b0, rsp_valid_o}, 32'h1);
      check("bp_data", ld_data_o, 32'h80ADBEEF);
      check("bp_ready", {31'b0, req_ready_o}, 32'h0);
      @(posedge clk_i); #1;
    end
    rsp_ready_i = 1'b1;
    check("bp_valid6", {31'b0, rsp_valid_o}, 32'h1);
    @(posedge clk_i); #1;
    check("bp_done", {31'b0, rsp_valid_o}, 32'h0);
    check("bp_ready_after", {31'b0, req_ready_o}, 32'h1);

    // misaligned half store and word load
    do_req(1'b1, 32'h000, 4'b0111, 32'h11223344, rd, er, lat);
    do_req(1'b1, 32'h003, 4'b0011, 32'h0000AABB, rd, er, lat);
    check("mis_sh_lat", 32'(lat), 32'd1);
`ifdef LSU_MISALIGN_CHK_EN
    check("mis_sh_err", {31'b0, er}, 32'h1);
    check("mis_sh_data", rd, 32'h0);
    do_req(1'b0, 32'h000, 4'b0111, 32'h0, rd, er, lat);
    check("mis_mem", rd, 32'h11223344);
    do_req(1'b0, 32'h006, 4'b0111, 32'h0, rd, er, lat);
    check("mis_lw_err", {31'b0, er}, 32'h1);
    check("mis_lw_data", rd, 32'h0);
    check("mis_lw_lat", 32'(lat), 32'd1);
`else
    check("mis_sh_err", {31'b0, er}, 32'h0);
    do_req(1'b0, 32'h000, 4'b0111, 32'h0, rd, er, lat);
    check("mis_mem", rd, 32'hAABB3344);
    do_req(1'b0, 32'h006, 4'b0111, 32'h0, rd, er, lat);
    check("mis_lw_data", rd, 32'h80ADBEEF);
    check("mis_lw_lat", 32'(lat), 32'd2);
`endif

    // reset during READ
    do_req(1'b0, 32'h830, 4'b0111, 32'h0, rd, er, lat);
    st_en_i = 1'b0; addr_i = 32'h004; ld_op_i = 4'b0111;
    req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    check("rr_in_read", {31'b0, rsp_valid_o}, 32'h0);
    rst_ni = 1'b0;
    #1;
    check("rr_valid", {31'b0, rsp_valid_o}, 32'h0);
    check("rr_data", ld_data_o, 32'h0);
    check("rr_err", {31'b0, err_o}, 32'h0);
    check("rr_leds", io_lcd_o | io_ledg_o | io_ledr_o, 32'h0);
    check("rr_hex", {31'b0, io_hex_o == '0}, 32'h1);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    saw_rsp = 1'b0;
    repeat (4) begin
      @(posedge clk_i); #1;
      if (rsp_valid_o) saw_rsp = 1'b1;
    end
    check("rr_no_rsp", {31'b0, saw_rsp}, 32'h0);
    check("rr_ready", {31'b0, req_ready_o}, 32'h1);
    do_req(1'b0, 32'h004, 4'b0111, 32'h0, rd, er, lat);
    check("rr_dmem_kept", rd, 32'h80ADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
